// File: rtl/bp_cfg_table_broadcast.sv
// Host-writable (addr, data) cfg table. On start, every valid entry is broadcast to every
// masked core over one valid/ready write channel, with credit-limited, in-order acks.
module bp_cfg_table_broadcast #(
    parameter int num_core_p        = 4,
    parameter int num_entries_p     = 8,
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 64,
    parameter int max_outstanding_p = 4,
    localparam int CoreW = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int EntW  = (num_entries_p > 1) ? $clog2(num_entries_p) : 1,
    localparam int OutW  = $clog2(max_outstanding_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        tbl_w_v_i,
    input  logic [EntW-1:0]             tbl_w_idx_i,
    input  logic                        tbl_w_en_i,
    input  logic [cfg_addr_width_p-1:0] tbl_w_addr_i,
    input  logic [cfg_data_width_p-1:0] tbl_w_data_i,
    input  logic [num_core_p-1:0]       core_mask_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [CoreW-1:0]            cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ack_v_i
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

    state_t                      r_state;
    logic [num_entries_p-1:0]    r_valid;
    logic [cfg_addr_width_p-1:0] r_tbl_addr [num_entries_p];
    logic [cfg_data_width_p-1:0] r_tbl_data [num_entries_p];
    logic [num_core_p-1:0]       r_mask;
    logic [CoreW-1:0]            r_core;
    logic [EntW-1:0]             r_entry;
    logic [OutW-1:0]             r_outstanding;
    logic                        r_busy, r_done, r_err, r_stale;
    logic                        r_cfg_v;
    logic [CoreW-1:0]            r_cfg_core;
    logic [cfg_addr_width_p-1:0] r_cfg_addr;
    logic [cfg_data_width_p-1:0] r_cfg_data;

    logic            w_live, w_acc, w_ack, w_last, w_adv, w_ack_err, w_credit;
    logic            w_nlive, w_slive, w_tbl_we;
    logic [CoreW-1:0] w_ncore;
    logic [EntW-1:0]  w_nentry;
    logic [OutW-1:0]  w_out_nxt;

    always_comb begin
        w_tbl_we = tbl_w_v_i && (r_state == S_IDLE || r_state == S_DONE);
        w_live   = r_mask[r_core] & r_valid[r_entry];
        w_acc    = r_cfg_v & cfg_ready_i;
        w_ack    = cfg_ack_v_i & ~r_stale;
        w_last   = (r_core == CoreW'(num_core_p - 1)) && (r_entry == EntW'(num_entries_p - 1));
        w_adv    = (r_state == S_SEND) && (!w_live || w_acc);
        w_ncore  = r_core;
        w_nentry = r_entry;
        if (w_adv) begin
            if (r_entry == EntW'(num_entries_p - 1)) begin
                w_nentry = '0;
                w_ncore  = r_core + CoreW'(1);
            end else begin
                w_nentry = r_entry + EntW'(1);
            end
        end
        w_out_nxt = r_outstanding;
        w_ack_err = 1'b0;
        if (w_acc && !w_ack) begin
            w_out_nxt = r_outstanding + OutW'(1);
        end else if (!w_acc && w_ack) begin
            if (r_outstanding == '0) w_ack_err = 1'b1;
            else                     w_out_nxt = r_outstanding - OutW'(1);
        end
        // cfg_v is registered, so the next slot is judged against next cycle's credit
        w_credit = w_out_nxt < OutW'(max_outstanding_p);
        w_nlive  = r_mask[w_ncore] & r_valid[w_nentry] & w_credit;
        w_slive  = core_mask_i[0] & r_valid[0] & w_credit;
    end

    always_ff @(posedge clk_i) begin
        if (w_tbl_we) begin
            r_tbl_addr[tbl_w_idx_i] <= tbl_w_addr_i;
            r_tbl_data[tbl_w_idx_i] <= tbl_w_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_mask        <= '0;
            r_core        <= '0;
            r_entry       <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_stale       <= 1'b1;
            r_cfg_v       <= 1'b0;
            r_cfg_core    <= '0;
            r_cfg_addr    <= '0;
            r_cfg_data    <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_done        <= 1'b0;
            if (w_tbl_we) r_valid[tbl_w_idx_i] <= tbl_w_en_i;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_state <= S_SEND;
                    r_mask  <= core_mask_i;
                    r_core  <= '0;
                    r_entry <= '0;
                    r_busy  <= 1'b1;
                    r_err   <= 1'b0;
                    // Acks still in flight from before a reset are dropped until the next start
                    r_stale <= 1'b0;
                    r_cfg_v <= w_slive;
                    if (w_slive) begin
                        r_cfg_core <= '0;
                        r_cfg_addr <= r_tbl_addr[0];
                        r_cfg_data <= r_tbl_data[0];
                    end
                end
                S_SEND: if (w_adv && w_last) begin
                    r_state <= S_DRAIN;
                    r_cfg_v <= 1'b0;
                end else begin
                    r_core  <= w_ncore;
                    r_entry <= w_nentry;
                    r_cfg_v <= w_nlive;
                    if (w_nlive) begin
                        r_cfg_core <= w_ncore;
                        r_cfg_addr <= r_tbl_addr[w_nentry];
                        r_cfg_data <= r_tbl_data[w_nentry];
                    end
                end
                S_DRAIN: if (r_outstanding == '0) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_ack_err) r_err <= 1'b1;
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign cfg_v_o    = r_cfg_v;
    assign cfg_core_o = r_cfg_core;
    assign cfg_addr_o = r_cfg_addr;
    assign cfg_data_o = r_cfg_data;

endmodule

// File: tb/tb_bp_cfg_table_broadcast.sv
// Directed bench for bp_cfg_table_broadcast: expected writes queued by stimulus,
// popped and compared by a monitor that also models the ack responder.
module tb_bp_cfg_table_broadcast;

    logic        clk = 1'b0;
    logic        reset_n_i, tbl_w_v_i, tbl_w_en_i, start_i, cfg_ready_i, cfg_ack_v_i;
    logic [1:0]  tbl_w_idx_i, core_mask_i;
    logic [15:0] tbl_w_addr_i, cfg_addr_o;
    logic [63:0] tbl_w_data_i, cfg_data_o;
    logic        busy_o, done_o, err_o, cfg_v_o;
    logic [0:0]  cfg_core_o;

    bp_cfg_table_broadcast #(
        .num_core_p(2), .num_entries_p(4), .cfg_addr_width_p(16),
        .cfg_data_width_p(64), .max_outstanding_p(2)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .tbl_w_v_i(tbl_w_v_i), .tbl_w_idx_i(tbl_w_idx_i), .tbl_w_en_i(tbl_w_en_i),
        .tbl_w_addr_i(tbl_w_addr_i), .tbl_w_data_i(tbl_w_data_i),
        .core_mask_i(core_mask_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_core_o(cfg_core_o),
        .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ack_v_i(cfg_ack_v_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]  core;
        logic [15:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_addr [4];
    logic [63:0] m_data [4];
    int n_chk = 0, n_pass = 0;
    int n_acc = 0, n_done = 0, n_vcyc = 0, pend = 0, cyc_cnt = 0, t_last_ack = 0, t_done = 0;
    bit ack_en = 1'b1, force_ack = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor + ack responder: acks one per cycle from the pending pool when enabled
    initial begin
        exp_t e;
        cfg_ack_v_i = 1'b0;
        forever begin
            @(negedge clk); #2;
            cyc_cnt++;
            if (force_ack || (ack_en && pend > 0)) begin
                cfg_ack_v_i = 1'b1;
                if (ack_en && pend > 0) pend--;
                t_last_ack = cyc_cnt;
            end else begin
                cfg_ack_v_i = 1'b0;
            end
            if (done_o === 1'b1) begin n_done++; t_done = cyc_cnt; end
            if (cfg_v_o === 1'b1) n_vcyc++;
            if (cfg_v_o === 1'b1 && cfg_ready_i === 1'b1) begin
                n_acc++;
                pend++;
                chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_core", 64'(cfg_core_o), 64'(e.core));
                    chk("wr_addr", 64'(cfg_addr_o), 64'(e.addr));
                    chk("wr_data", cfg_data_o, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: %0d/%0d checks passed before timeout", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    task automatic tbl_wr(input int idx, input bit en, input logic [15:0] a,
                          input logic [63:0] d, input bit apply);
        @(negedge clk);
        tbl_w_v_i = 1'b1; tbl_w_idx_i = 2'(idx); tbl_w_en_i = en;
        tbl_w_addr_i = a; tbl_w_data_i = d;
        @(negedge clk);
        tbl_w_v_i = 1'b0;
        if (apply) begin m_addr[idx] = a; m_data[idx] = d; end
    endtask

    task automatic push(input int c, input int e);
        exp_t x;
        x.core = 1'(c); x.addr = m_addr[e]; x.data = m_data[e];
        exp_q.push_back(x);
    endtask

    task automatic do_start(input logic [1:0] mask);
        @(negedge clk); core_mask_i = mask; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n0 = n_done;
        int k = 0;
        while (n_done == n0 && k < 200) begin @(negedge clk); k++; end
        chk({nm, "_done_seen"}, 64'(n_done != n0), 64'd1);
        @(negedge clk);
    endtask

    // Zero live slots: done_o exactly one cycle, 10 cycles after the start cycle
    task automatic lat_zero(input string nm, input logic [1:0] mask);
        int first = -1;
        int nhi = 0;
        int v0 = n_vcyc;
        @(negedge clk); core_mask_i = mask; start_i = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start_i = 1'b0;
            if (done_o === 1'b1) begin nhi++; if (first < 0) first = i; end
        end
        chk({nm, "_latency"}, 64'(first), 64'd10);
        chk({nm, "_done_pulses"}, 64'(nhi), 64'd1);
        chk({nm, "_no_cfg_v"}, 64'(n_vcyc - v0), 64'd0);
    endtask

    function automatic logic [63:0] dval(input int e);
        return {32'hC0DE_0000 + 32'(e), 32'h1234_5670 + 32'(e)};
    endfunction

    initial begin
        int a0, d0, k;
        reset_n_i = 1'b0; tbl_w_v_i = 1'b0; tbl_w_idx_i = '0; tbl_w_en_i = 1'b0;
        tbl_w_addr_i = '0; tbl_w_data_i = '0; core_mask_i = '0; start_i = 1'b0;
        cfg_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_cfg_v", 64'(cfg_v_o), 64'd0);
        chk("rst_core", 64'(cfg_core_o), 64'd0);
        chk("rst_addr", 64'(cfg_addr_o), 64'd0);
        chk("rst_data", cfg_data_o, 64'd0);
        reset_n_i = 1'b1;

        // 1: entries 0,2 valid, both cores, acks follow accepts
        tbl_wr(0, 1'b1, 16'h0010, dval(0), 1'b1);
        tbl_wr(2, 1'b1, 16'h0012, dval(2), 1'b1);
        push(0, 0); push(0, 2); push(1, 0); push(1, 2);
        a0 = n_acc; d0 = n_done;
        do_start(2'b11);
        chk("t1_busy", 64'(busy_o), 64'd1);
        wait_done("t1");
        repeat (3) @(negedge clk);
        chk("t1_accepts", 64'(n_acc - a0), 64'd4);
        chk("t1_done_count", 64'(n_done - d0), 64'd1);
        chk("t1_idle", 64'(busy_o), 64'd0);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // 2: empty mask
        lat_zero("t2", 2'b00);

        // 3: all valid, acks withheld -> credit stall, then drain on release
        for (int e = 0; e < 4; e++) tbl_wr(e, 1'b1, 16'h0030 + 16'(e), dval(16 + e), 1'b1);
        for (int c = 0; c < 2; c++) for (int e = 0; e < 4; e++) push(c, e);
        ack_en = 1'b0;
        a0 = n_acc;
        do_start(2'b11);
        repeat (20) @(negedge clk);
        chk("t3_credit_accepts", 64'(n_acc - a0), 64'd2);
        chk("t3_stall_v", 64'(cfg_v_o), 64'd0);
        chk("t3_stall_busy", 64'(busy_o), 64'd1);
        ack_en = 1'b1;
        wait_done("t3");
        chk("t3_accepts", 64'(n_acc - a0), 64'd8);
        chk("t3_drain_gap", 64'(t_done - t_last_ack), 64'd2);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // 4: only entry 1 for core 0, ready held low on the live slot
        tbl_wr(0, 1'b0, 16'h0000, 64'd0, 1'b0);
        tbl_wr(1, 1'b1, 16'h0041, dval(41), 1'b1);
        tbl_wr(2, 1'b0, 16'h0000, 64'd0, 1'b0);
        tbl_wr(3, 1'b0, 16'h0000, 64'd0, 1'b0);
        push(0, 1);
        cfg_ready_i = 1'b0;
        a0 = n_acc;
        do_start(2'b01);
        k = 0;
        while (cfg_v_o !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        chk("t4_v_raised", 64'(cfg_v_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_v", 64'(cfg_v_o), 64'd1);
            chk("t4_hold_core", 64'(cfg_core_o), 64'd0);
            chk("t4_hold_addr", 64'(cfg_addr_o), 64'(m_addr[1]));
            chk("t4_hold_data", cfg_data_o, m_data[1]);
            @(negedge clk);
        end
        cfg_ready_i = 1'b1;
        @(negedge clk);
        chk("t4_accepted", 64'(n_acc - a0), 64'd1);
        chk("t4_v_dropped", 64'(cfg_v_o), 64'd0);
        wait_done("t4");

        // 5: spurious ack sets sticky err; start clears; busy table write ignored
        @(negedge clk); force_ack = 1'b1;
        @(negedge clk); force_ack = 1'b0;
        chk("t5_err_set", 64'(err_o), 64'd1);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        push(0, 1);
        do_start(2'b01);
        chk("t5_err_cleared", 64'(err_o), 64'd0);
        tbl_wr(1, 1'b0, 16'h0099, 64'h99, 1'b0);
        wait_done("t5a");
        push(0, 1);
        do_start(2'b01);
        wait_done("t5b");
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
        chk("t5_err_clean", 64'(err_o), 64'd0);

        // 6: reset during a credit stall, late acks must be ignored
        tbl_wr(0, 1'b1, 16'h0060, dval(60), 1'b1);
        tbl_wr(2, 1'b1, 16'h0062, dval(62), 1'b1);
        tbl_wr(3, 1'b1, 16'h0063, dval(63), 1'b1);
        push(0, 0); push(0, 1);
        ack_en = 1'b0;
        a0 = n_acc;
        do_start(2'b11);
        k = 0;
        while (n_acc - a0 < 2 && k < 20) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        chk("t6_two_out", 64'(n_acc - a0), 64'd2);
        chk("t6_busy_pre", 64'(busy_o), 64'd1);
        reset_n_i = 1'b0;
        @(negedge clk); reset_n_i = 1'b1;
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_cfg_v", 64'(cfg_v_o), 64'd0);
        chk("t6_core", 64'(cfg_core_o), 64'd0);
        chk("t6_addr", 64'(cfg_addr_o), 64'd0);
        chk("t6_data", cfg_data_o, 64'd0);
        chk("t6_done", 64'(done_o), 64'd0);
        ack_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_late_ack_err", 64'(err_o), 64'd0);
        chk("t6_late_ack_busy", 64'(busy_o), 64'd0);
        // reset cleared all valid bits, so nothing is live
        lat_zero("t6_post", 2'b11);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
        chk("t6_err_final", 64'(err_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
